// File: rtl/dog_intro_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dog_intro_sequencer_if
// Brief   : Control/strobe inputs and sprite outputs of the dog intro sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface dog_intro_sequencer_if;
  logic       frame_clk;
  logic       start;
  logic       skip;
  logic [9:0] Dog_X;
  logic [9:0] Dog_Y;
  logic [4:0] Frame;
  logic       jump2Signal;
  logic       resetSignal;
  logic       busy;
  logic       intro_done;

  modport master (
    output frame_clk, start, skip,
    input  Dog_X, Dog_Y, Frame, jump2Signal, resetSignal, busy, intro_done
  );

  modport slave (
    input  frame_clk, start, skip,
    output Dog_X, Dog_Y, Frame, jump2Signal, resetSignal, busy, intro_done
  );
endinterface
`default_nettype wire

// File: rtl/dog_intro_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dog_intro_sequencer
// Brief   : Walk / sniff / jump / fall animation of the dog sprite, one step per frame.
// Revision: 1.0 - initial release
// ============================================================================
module dog_intro_sequencer #(
  parameter int WALK_START_X = 0,
  parameter int WALK_END_X   = 240,
  parameter int START_Y      = 330,
  parameter int STEP_X       = 1,
  parameter int ANIM_DIV     = 6,
  parameter int SNIFF_TICKS  = 60,
  parameter int JUMP_PEAK_Y  = 200,
  parameter int LAND_Y       = 310,
  parameter int JUMP_STEP    = 2
) (
  input  logic                  vga_clk,
  input  logic                  Reset,
  dog_intro_sequencer_if.slave  bus_if
);

  localparam int ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int SNIFF_W = (SNIFF_TICKS > 0) ? $clog2(SNIFF_TICKS + 1) : 1;

  localparam logic [9:0]         c_walk_start_x = 10'(WALK_START_X);
  localparam logic [9:0]         c_walk_end_x   = 10'(WALK_END_X);
  localparam logic [9:0]         c_start_y      = 10'(START_Y);
  localparam logic [9:0]         c_peak_y       = 10'(JUMP_PEAK_Y);
  localparam logic [9:0]         c_land_y       = 10'(LAND_Y);
  localparam logic [9:0]         c_jump_step    = 10'(JUMP_STEP);
  localparam logic [10:0]        c_step_x11     = 11'(STEP_X);
  localparam logic [10:0]        c_jump_step11  = 11'(JUMP_STEP);
  localparam logic [ANIM_W-1:0]  c_anim_last    = ANIM_W'(ANIM_DIV - 1);
  localparam logic [SNIFF_W-1:0] c_sniff_ticks  = SNIFF_W'(SNIFF_TICKS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WALK    = 3'd1,
    S_SNIFF   = 3'd2,
    S_JUMP_UP = 3'd3,
    S_FALL    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [9:0]          dog_x_q, dog_x_d;
  logic [9:0]          dog_y_q, dog_y_d;
  logic [4:0]          frame_q, frame_d;
  logic [ANIM_W-1:0]   anim_q, anim_d;
  logic [SNIFF_W-1:0]  sniff_q, sniff_d;
  logic                jump2_q, jump2_d;
  logic                hidden_q, hidden_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                f1_q, f2_q;

  logic                tick;
  logic                anim_wrap;
  logic [ANIM_W-1:0]   anim_next;
  logic [SNIFF_W-1:0]  sniff_inc;
  logic [10:0]         walk_sum;
  logic [10:0]         jump_limit;
  logic [10:0]         fall_sum;

  // Rising-edge detect of the frame strobe; a long high level yields one tick.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
    end else begin
      f1_q <= bus_if.frame_clk;
      f2_q <= f1_q;
    end
  end

  assign tick       = f1_q & ~f2_q;
  assign anim_wrap  = (anim_q == c_anim_last);
  assign anim_next  = anim_wrap ? '0 : anim_q + ANIM_W'(1);
  assign sniff_inc  = sniff_q + SNIFF_W'(1);
  assign walk_sum   = {1'b0, dog_x_q} + c_step_x11;
  assign jump_limit = {1'b0, c_peak_y} + c_jump_step11;
  assign fall_sum   = {1'b0, dog_y_q} + c_jump_step11;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      dog_x_q  <= c_walk_start_x;
      dog_y_q  <= c_start_y;
      frame_q  <= 5'd0;
      anim_q   <= '0;
      sniff_q  <= '0;
      jump2_q  <= 1'b0;
      hidden_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dog_x_q  <= dog_x_d;
      dog_y_q  <= dog_y_d;
      frame_q  <= frame_d;
      anim_q   <= anim_d;
      sniff_q  <= sniff_d;
      jump2_q  <= jump2_d;
      hidden_q <= hidden_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dog_x_d  = dog_x_q;
    dog_y_d  = dog_y_q;
    frame_d  = frame_q;
    anim_d   = anim_q;
    sniff_d  = sniff_q;
    jump2_d  = jump2_q;
    hidden_d = hidden_q;
    done_d   = 1'b0;

    // Skip leaves position and frame frozen; only the visibility flags change.
    if ((state_q != S_IDLE) && bus_if.skip) begin
      state_d  = S_IDLE;
      jump2_d  = 1'b0;
      hidden_d = 1'b1;
      done_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            state_d  = S_WALK;
            dog_x_d  = c_walk_start_x;
            dog_y_d  = c_start_y;
            frame_d  = 5'd0;
            anim_d   = '0;
            sniff_d  = '0;
            jump2_d  = 1'b0;
            hidden_d = 1'b0;
          end
        end

        S_WALK: begin
          if (tick) begin
            anim_d = anim_next;
            if (anim_wrap) begin
              frame_d = {3'b000, frame_q[1:0] + 2'd1};
            end
            if (walk_sum >= {1'b0, c_walk_end_x}) begin
              dog_x_d = c_walk_end_x;
              state_d = S_SNIFF;
              frame_d = 5'd4;
              anim_d  = '0;
              sniff_d = '0;
            end else begin
              dog_x_d = walk_sum[9:0];
            end
          end
        end

        S_SNIFF: begin
          if (tick) begin
            sniff_d = sniff_inc;
            anim_d  = anim_next;
            if (anim_wrap) begin
              frame_d = (frame_q == 5'd4) ? 5'd5 : 5'd4;
            end
            if (sniff_inc == c_sniff_ticks) begin
              state_d = S_JUMP_UP;
              frame_d = 5'd6;
            end
          end
        end

        S_JUMP_UP: begin
          if (tick) begin
            if ({1'b0, dog_y_q} <= jump_limit) begin
              dog_y_d = c_peak_y;
              state_d = S_FALL;
              frame_d = 5'd7;
              jump2_d = 1'b1;
            end else begin
              dog_y_d = dog_y_q - c_jump_step;
            end
          end
        end

        S_FALL: begin
          if (tick) begin
            if (fall_sum >= {1'b0, c_land_y}) begin
              dog_y_d  = c_land_y;
              state_d  = S_IDLE;
              jump2_d  = 1'b0;
              hidden_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              dog_y_d = fall_sum[9:0];
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus_if.Dog_X       = dog_x_q;
  assign bus_if.Dog_Y       = dog_y_q;
  assign bus_if.Frame       = frame_q;
  assign bus_if.jump2Signal = jump2_q;
  assign bus_if.resetSignal = hidden_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.intro_done  = done_q;

endmodule
`default_nettype wire

// File: doc/dog_intro_sequencer.md
# dog_intro_sequencer

Drives the dog sprite through the round-intro animation: hidden, walk, sniff, jump, then fall behind the grass. It produces `Dog_X`, `Dog_Y`, `Frame`, `jump2Signal` and `resetSignal`, which feed the color mapper's dog sprite logic. It sits beside the color mapper in the top level and is clocked by `vga_clk`. Motion advances once per video frame, on rising edges of `frame_clk`.

## Interface
Parameters:
- WALK_START_X, 0, dog X at start of walk
- WALK_END_X, 240, X where walking stops
- START_Y, 330, dog Y during walk/sniff
- STEP_X, 1, X pixels per frame tick while walking
- ANIM_DIV, 6, frame ticks per animation-frame change
- SNIFF_TICKS, 60, frame ticks spent sniffing
- JUMP_PEAK_Y, 200, apex Y of the jump
- LAND_Y, 310, Y at which the fall ends
- JUMP_STEP, 2, Y pixels per frame tick while jumping/falling

Ports:
- vga_clk  in  1  pixel clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  vsync-rate strobe (level), synchronous to vga_clk
- start  in  1  begin intro (sampled only in IDLE)
- skip  in  1  abort intro (sampled only outside IDLE)
- Dog_X  out  10  sprite top-left X
- Dog_Y  out  10  sprite top-left Y
- Frame  out  5  sprite frame index
- jump2Signal  out  1  high while falling (mapper clips dog at DrawY ≥ 300)
- resetSignal  out  1  high = dog hidden
- busy  out  1  high in any state other than IDLE
- intro_done  out  1  one-cycle pulse when intro ends (normal or skip)

## Operation
- Tick: `frame_clk` is registered into f1, then f2. tick = f1 & ~f2. One tick per frame_clk rise, however long frame_clk stays high.
- States: IDLE, WALK, SNIFF, JUMP_UP, FALL. All outputs are registered.
- Reset values: state IDLE, Dog_X=WALK_START_X, Dog_Y=START_Y, Frame=0, jump2Signal=0, resetSignal=1, busy=0, intro_done=0, anim and sniff counters 0.
- IDLE: start=1 → WALK. Dog_X=WALK_START_X, Dog_Y=START_Y, Frame=0, counters cleared, resetSignal=0. No movement occurs on the start cycle, even if a tick coincides with it.
- WALK, per tick:
  - If Dog_X+STEP_X ≥ WALK_END_X: Dog_X=WALK_END_X, → SNIFF, Frame=4, anim and sniff counters cleared.
  - Otherwise Dog_X += STEP_X.
  - The anim counter counts 0..ANIM_DIV-1. On wrap, Frame = (Frame+1) mod 4, so walk frames are 0–3.
- SNIFF, per tick:
  - The sniff counter increments.
  - On anim wrap, Frame toggles between 4 and 5.
  - When the sniff counter reaches SNIFF_TICKS: → JUMP_UP, Frame=6.
- JUMP_UP, per tick:
  - If Dog_Y−JUMP_STEP ≤ JUMP_PEAK_Y: Dog_Y=JUMP_PEAK_Y, → FALL, Frame=7, jump2Signal=1.
  - Otherwise Dog_Y −= JUMP_STEP.
- FALL, per tick:
  - If Dog_Y+JUMP_STEP ≥ LAND_Y: Dog_Y=LAND_Y, → IDLE, jump2Signal=0, resetSignal=1, intro_done=1 for one cycle.
  - Otherwise Dog_Y += JUMP_STEP.
- skip=1 in any non-IDLE state → IDLE on the next edge with the same exit as landing: resetSignal=1, jump2Signal=0, intro_done pulse. Dog_X, Dog_Y and Frame hold their last values.
- skip beats a simultaneous tick. start outside IDLE and skip in IDLE are ignored.
- Arithmetic is unsigned 10-bit. The clamp comparisons use 11-bit sums, so there is no wrap-around.

## Timing
- A frame_clk rise first sampled into f1 at edge k produces an output update at edge k+1.
- start/skip to state change: 1 cycle.
- busy equals (state ≠ IDLE) and is registered with the state.
- intro_done is high exactly one cycle, coincident with the first IDLE cycle.
- Reset asserted mid-intro forces the reset values immediately (asynchronously). After release, the block stays IDLE until a new start.
- Default full intro length: 240 walk + 60 sniff + 65 jump + 55 fall = 420 ticks.

## Test plan
- Reset asserted then released → Dog_X=0, Dog_Y=330, Frame=0, resetSignal=1, jump2Signal=0, busy=0. 10 ticks with start=0 → outputs unchanged.
- start pulse then 6 ticks → Dog_X=6, Frame=1. After 24 ticks → Frame=0. After 240 ticks → Dog_X=240, Frame=4, state SNIFF.
- 60 further ticks → Frame=6. After 65 more → Dog_Y=200, Frame=7, jump2Signal=1. After 55 more → Dog_Y=310, resetSignal=1, jump2Signal=0, intro_done high 1 cycle, busy=0.
- frame_clk held high 50 cycles during WALK → exactly one tick (Dog_X +1). start re-pulsed mid-WALK → no effect.
- skip asserted at Dog_X=100 in WALK, coincident with a tick → next edge IDLE, Dog_X stays 100, resetSignal=1, one intro_done pulse.
- Reset asserted asynchronously in JUMP_UP at Dog_Y=250 → outputs go to reset values before the next vga_clk edge. Fresh start replays the walk from X=0.
